display_scheduler: RTL
======================

# display_scheduler

Time-shares the team's two-digit seven-segment display among up to NUM_REQ requesters, such as score, round timer and lives count. A round-robin arbiter picks one requester and latches its 7-bit value. A sequential split engine then produces tens/ones BCD digits by repeated subtraction of 10, using one shared subtractor and no divider. The digits are held on the display for HOLD_CYCLES before the next arbitration. The block sits between the game-logic producers and the two seven-segment decoder instances.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- HOLD_CYCLES, 1000, cycles a result stays displayed before re-arbitration (≥2)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset; asynchronous, active-low
- req  input  NUM_REQ  level request per requester; bit i = requester i
- value_in  input  7*NUM_REQ  flattened values; requester i at bits [7i+6:7i]
- grant  output  NUM_REQ  one-hot, one-cycle pulse on the edge a requester's value is captured
- leftDigit  output  4  tens digit, BCD 0..9
- rightDigit  output  4  ones digit, BCD 0..9
- digits_valid  output  1  high once any result has been displayed since reset
- busy  output  1  high while in SPLIT
- owner  output  3  index of the requester whose value is currently displayed
- overflow  output  1  displayed value was clamped (source > 99)

## Operation
- States: IDLE, SPLIT, SHOW. Reset state is IDLE.
- IDLE, req == 0: hold. All outputs keep their values; the last result stays displayed.
- IDLE, req != 0: round-robin pick.
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - On the edge: grant[w] pulses; rem ← min(value_in[w], 99); tens ← 0; ovf_next ← (value_in[w] > 99); ptr ← (w+1) mod NUM_REQ; go to SPLIT.
- SPLIT, rem ≥ 10: rem ← rem − 10; tens ← tens + 1.
- SPLIT, rem < 10:
  - leftDigit ← tens, rightDigit ← rem[3:0], owner ← w, overflow ← ovf_next, digits_valid ← 1.
  - hold counter ← HOLD_CYCLES − 1; go to SHOW.
- SHOW: decrement the hold counter. At 0, go to IDLE.
- The value is sampled only on the capture edge. Changes to req or value_in during SPLIT or SHOW do not affect the current result.
- A requester that drops req before it is granted is skipped. Requests are not queued.
- The display outputs change only on the SPLIT→SHOW edge. The old digits stay stable throughout SPLIT, so the display does not flicker.
- Width rules:
  - rem is 7 bits and tens is 4 bits.
  - The clamp guarantees tens ≤ 9, so no BCD overflow is possible.
  - Values 100..127 display as 99 with overflow = 1.

## Timing
- Reset values, all outputs: grant = 0, leftDigit = 0, rightDigit = 0, digits_valid = 0, busy = 0, owner = 0, overflow = 0. Internal: ptr = 0, state IDLE.
- Asynchronous reset mid-SPLIT or mid-SHOW takes effect immediately. The partial result is discarded and the first post-reset grant goes to the lowest requesting index.
- Latency from the capture edge to the new digits is tens + 1 edges: value 0 → 1 edge, value 99 → 10 edges. busy is high for exactly those tens + 1 cycles.
- The digits remain for HOLD_CYCLES cycles in SHOW, plus one cycle in IDLE. Under continuous requests, the next grant occurs HOLD_CYCLES + 1 edges after the display update.
- Only one grant bit is ever high, and never on two consecutive cycles.

## Structure
- Shared package / header display_pkg:
  - state encodings ST_IDLE, ST_SPLIT, ST_SHOW
  - MAX_DISPLAY = 99, DIGIT_STEP = 10
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs req, ptr, enable
  - outputs one-hot winner and encoded index
  - purely combinational; ptr is held in the parent
- The split engine, hold counter and FSM live in display_scheduler. They reuse the leftDigit/rightDigit output format of the existing splitter, so the 7-segment decoders connect unchanged.

## Test plan
- Reset, then req=001 with value0=57 → grant=001 for one cycle; six edges later leftDigit=5, rightDigit=7, owner=0, digits_valid=1; busy high 6 cycles.
- Edge values, HOLD_CYCLES=4:
  - value0=0 → 0/0 after 1 edge.
  - value0=99 → 9/9 after 10 edges.
  - value0=120 → 9/9 with overflow=1.
- Round robin: req=111 held, values 12/34/56 → grants 001, 010, 100, 001 in order, each HOLD_CYCLES+1 edges after the preceding display update; digits cycle 1/2, 3/4, 5/6.
- Value and req stability: change value0 from 57 to 83 and drop req mid-SPLIT → display still 5/7. req=0 afterwards → digits held indefinitely, no grant.
- Reset mid-SPLIT on value 88 with a prior display of 4/2 → all outputs return to their reset values immediately. After release, req=110 → grant=010 first.
- Skipped requester: req=101 with ptr=1 → grant=100, then grant=001; a requester dropping req before its turn is never granted.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package display_pkg;

    // Scheduler FSM encoding; also visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Largest value the two-digit display can show.
    localparam logic [6:0] MAX_DISPLAY = 7'd99;
    // Amount removed per split step (one tens digit).
    localparam logic [6:0] DIGIT_STEP  = 7'd10;

    // Saturate a 7-bit source value to the displayable range.
    function automatic logic [6:0] clamp_display(input logic [6:0] v);
        return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
    endfunction

endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: finds the first active request at or
// after ptr, wrapping modulo NUM_REQ. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   index
);

    // Walk candidates from farthest to nearest so the nearest active one wins.
    always_comb begin
        int         cand;
        logic [PTR_W-1:0] cand_idx;
        winner   = '0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = int'(ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_idx = cand[PTR_W-1:0];
                if (req[cand_idx]) begin
                    winner           = '0;
                    winner[cand_idx] = 1'b1;
                    index            = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares a two-digit seven-segment display among NUM_REQ requesters.
// Handshake: a requester holds req high; the value is sampled only on the
// edge where its grant bit pulses, and nothing is queued after that.
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] value_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic [3:0]           leftDigit,
    output logic [3:0]           rightDigit,
    output logic                 digits_valid,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 overflow,
    output logic [1:0]           state_dbg
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    w_idx;
    logic [6:0]          rem;
    logic [3:0]          tens;
    logic                ovf_next;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0]  arb_winner;
    logic [PTR_W-1:0]    arb_index;
    logic [6:0]          sel_value;
    logic [PTR_W-1:0]    ptr_after;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .enable (state == ST_IDLE),
        .winner (arb_winner),
        .index  (arb_index)
    );

    // Select the winner's value and the pointer position just past it.
    always_comb begin
        sel_value = value_in[7*int'(arb_index) +: 7];
        ptr_after = (arb_index == LAST_IDX) ? '0 : arb_index + 1'b1;
    end

    assign state_dbg = state;

    // Scheduler FSM: capture, repeated-subtraction split, then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            w_idx        <= '0;
            rem          <= '0;
            tens         <= '0;
            ovf_next     <= 1'b0;
            hold_cnt     <= '0;
            grant        <= '0;
            leftDigit    <= '0;
            rightDigit   <= '0;
            digits_valid <= 1'b0;
            busy         <= 1'b0;
            owner        <= '0;
            overflow     <= 1'b0;
        end else begin
            grant <= '0;
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        grant    <= arb_winner;
                        w_idx    <= arb_index;
                        rem      <= clamp_display(sel_value);
                        tens     <= '0;
                        ovf_next <= (sel_value > MAX_DISPLAY);
                        ptr      <= ptr_after;
                        busy     <= 1'b1;
                        state    <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    if (rem >= DIGIT_STEP) begin
                        rem  <= rem - DIGIT_STEP;
                        tens <= tens + 4'd1;
                    end else begin
                        // Display outputs move only here, so the old digits
                        // stay steady for the whole split.
                        leftDigit    <= tens;
                        rightDigit   <= rem[3:0];
                        owner        <= 3'(w_idx);
                        overflow     <= ovf_next;
                        digits_valid <= 1'b1;
                        busy         <= 1'b0;
                        hold_cnt     <= HOLD_RELOAD;
                        state        <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
